// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, operation encoding and a
// constant-evaluable log2 helper for sizing pointers.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_ADDR_W = 3;

  // Accepted-operation encoding, {push_accepted, pop_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_reg_file.sv
// FIFO storage: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port so the head entry falls through with no latency.
module fifo_reg_file import fifo_pkg::*; #(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              iClk,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Contents are deliberately not reset; the controller masks them via oEmpty.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write accepted data into the addressed slot.
  always_ff @(posedge iClk) begin
    if (iWrEn) begin
      mem_q[iWrAddr] <= iWrData;
    end
  end

  assign oRdData = mem_q[iRdAddr];

endmodule

// File: rtl/fifo_buf_param.sv
// Synchronous first-word-fall-through FIFO controller: pointers, occupancy,
// registered full/empty/threshold status and sticky overflow/underflow flags.
module fifo_buf_param import fifo_pkg::*; #(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned AF_LVL = (2 ** ADDR_W) - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iPush,
  input  logic              iPop,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iClrErr,
  output logic [DATA_W-1:0] oRdData,
  output logic              oFull,
  output logic              oEmpty,
  output logic              oAlmostFull,
  output logic              oAlmostEmpty,
  output logic [ADDR_W:0]   oCount,
  output logic              oOverflow,
  output logic              oUnderflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push_acc;
  logic             pop_acc;
  fifo_op_e         op;

  // Acceptance, pointer/count advance and status derived from the next count.
  always_comb begin
    // A pop while full frees the slot the simultaneous push writes into.
    push_acc = iPush && (!full_q || iPop);
    pop_acc  = iPop && !empty_q;
    op       = fifo_op_e'({push_acc, pop_acc});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q - CNT_W'(1);
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      default: ;
    endcase
    full_d  = (32'(count_d) == DEPTH);
    empty_d = (count_d == '0);
    af_d    = (32'(count_d) >= AF_LVL);
    ae_d    = (32'(count_d) <= AE_LVL);
    // A fresh error outranks a clear request in the same cycle.
    ovf_d   = (iPush && full_q && !iPop) || (ovf_q && !iClrErr);
    udf_d   = (iPop && empty_q) || (udf_q && !iClrErr);
  end

  // Controller state, cleared immediately by the asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_LVL == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_reg_file (
    .iClk    (iClk),
    .iWrEn   (push_acc),
    .iWrAddr (wr_ptr_q),
    .iWrData (iWrData),
    .iRdAddr (rd_ptr_q),
    .oRdData (oRdData)
  );

  assign oFull        = full_q;
  assign oEmpty       = empty_q;
  assign oAlmostFull  = af_q;
  assign oAlmostEmpty = ae_q;
  assign oCount       = count_q;
  assign oOverflow    = ovf_q;
  assign oUnderflow   = udf_q;

endmodule

// File: tb/tb_fifo_buf_param.sv
// Bench for fifo_buf_param (DATA_W=8, ADDR_W=3, AF_LVL=6, AE_LVL=2):
// a directed vector table plus hand sequences for interleaving and reset.
module tb_fifo_buf_param;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iPush;
  logic       iPop;
  logic [7:0] iWrData;
  logic       iClrErr;
  logic [7:0] oRdData;
  logic       oFull;
  logic       oEmpty;
  logic       oAlmostFull;
  logic       oAlmostEmpty;
  logic [3:0] oCount;
  logic       oOverflow;
  logic       oUnderflow;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  fifo_buf_param #(
    .DATA_W (8),
    .ADDR_W (3),
    .AF_LVL (6),
    .AE_LVL (2)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iPush        (iPush),
    .iPop         (iPop),
    .iWrData      (iWrData),
    .iClrErr      (iClrErr),
    .oRdData      (oRdData),
    .oFull        (oFull),
    .oEmpty       (oEmpty),
    .oAlmostFull  (oAlmostFull),
    .oAlmostEmpty (oAlmostEmpty),
    .oCount       (oCount),
    .oOverflow    (oOverflow),
    .oUnderflow   (oUnderflow)
  );

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] wd;
    int         cnt;
    logic       ovf;
    logic       udf;
    logic       chk_rd;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic push, input logic pop, input logic clr,
                              input logic [7:0] wd, input int cnt, input logic ovf,
                              input logic udf, input logic chk_rd, input logic [7:0] rd);
    vec_t v;
    v.push = push; v.pop = pop; v.clr = clr; v.wd = wd; v.cnt = cnt;
    v.ovf = ovf; v.udf = udf; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  // Compare count, full, empty, almost-full, almost-empty and error flags.
  task automatic check_status(input string tag, input int cnt, input logic ovf, input logic udf);
    logic [9:0] act;
    logic [9:0] exp;
    act = {oCount, oFull, oEmpty, oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow};
    exp = {4'(cnt), (cnt == 8), (cnt == 0), (cnt >= 6), (cnt <= 2), ovf, udf};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s status: got cnt=%0d f/e/af/ae/ov/un=%b, required cnt=%0d f/e/af/ae/ov/un=%b",
               tag, act[9:6], act[5:0], exp[9:6], exp[5:0]);
    end
  endtask

  task automatic check_rd(input string tag, input logic [7:0] exp);
    checks++;
    if (oRdData !== exp) begin
      errors++;
      $display("FAIL %s rdata: got %02h, required %02h", tag, oRdData, exp);
    end
  endtask

  task automatic check_count(input string tag, input int exp);
    checks++;
    if (oCount !== 4'(exp)) begin
      errors++;
      $display("FAIL %s count: got %0d, required %0d", tag, oCount, exp);
    end
  endtask

  initial begin
    logic [7:0] mq[$];
    int         pushed;
    int         popped;
    int         cyc;
    logic       p;
    logic       q;
    logic       push_acc;
    logic       pop_acc;

    iRst = 1'b1; iPush = 1'b0; iPop = 1'b0; iWrData = 8'h00; iClrErr = 1'b0;

    // Fill 0x01..0x08; head stays 0x01, thresholds follow the count.
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 0, 0, 8'(k), k, 0, 0, 1, 8'h01));
    // Push while full: dropped, overflow set, head unchanged.
    vecs.push_back(mk(1, 0, 0, 8'hAA, 8, 1, 0, 1, 8'h01));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8, 0, 0, 1, 8'h01));
    // Push+pop while full: count stays 8, head advances to 0x02.
    vecs.push_back(mk(1, 1, 0, 8'h55, 8, 0, 0, 1, 8'h02));
    // Drain: 0x03..0x08 then 0x55; 0xAA never appears.
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk(0, 1, 0, 8'h00, 8 - i, 0, 0, 1, (i <= 6) ? 8'(i + 2) : 8'h55));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    // Push+pop while empty: push only, underflow set.
    vecs.push_back(mk(1, 1, 0, 8'h3C, 1, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 1, 8'h3C));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    // Pop while empty, then clear colliding with a new error, then clear.
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00));

    // Reset state, both during and after reset.
    @(negedge iClk);
    check_status("reset_held", 0, 0, 0);
    iRst = 1'b0;
    @(negedge iClk);
    check_status("reset_released", 0, 0, 0);
    $display("reset: cnt=%0d empty=%b full=%b", oCount, oEmpty, oFull);

    for (int i = 0; i < vecs.size(); i++) begin
      iPush = vecs[i].push; iPop = vecs[i].pop; iClrErr = vecs[i].clr; iWrData = vecs[i].wd;
      @(negedge iClk);
      check_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
      if (vecs[i].chk_rd) check_rd($sformatf("vec%0d", i), vecs[i].rd);
      $display("vec %0d: push=%b pop=%b clr=%b wd=%02h -> cnt=%0d rd=%02h ov=%b un=%b",
               i, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].wd, oCount, oRdData,
               oOverflow, oUnderflow);
    end
    iPush = 1'b0; iPop = 1'b0; iClrErr = 1'b0;

    // Random interleave of 20 pushes and 20 pops against a queue model.
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 20 && cyc < 400) begin
      p = (pushed < 20) && ($urandom_range(0, 1) == 1);
      q = ($urandom_range(0, 1) == 1);
      push_acc = p && (mq.size() < 8 || q);
      pop_acc  = q && (mq.size() > 0);
      if (pop_acc) check_rd($sformatf("rand%0d", cyc), mq[0]);
      iPush = p; iPop = q; iWrData = 8'(8'h80 + pushed);
      @(negedge iClk);
      if (pop_acc) begin
        void'(mq.pop_front());
        popped++;
      end
      if (push_acc) begin
        mq.push_back(iWrData);
        pushed++;
      end
      check_count($sformatf("rand%0d", cyc), mq.size());
      $display("rand %0d: push=%b pop=%b -> cnt=%0d pushed=%0d popped=%0d",
               cyc, p, q, oCount, pushed, popped);
      cyc++;
    end
    checks++;
    if (popped < 20) begin
      errors++;
      $display("FAIL rand_budget: got %0d pops, required 20", popped);
    end
    iPush = 1'b0; iPop = 1'b0; iClrErr = 1'b1;
    @(negedge iClk);
    iClrErr = 1'b0;

    // Set underflow, load 5 entries, then reset asynchronously mid-cycle.
    iPop = 1'b1;
    @(negedge iClk);
    iPop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iPush = 1'b1; iWrData = 8'(8'h11 + i);
      @(negedge iClk);
    end
    iPush = 1'b0;
    check_status("pre_async_reset", 5, 0, 1);
    #2 iRst = 1'b1;
    #1 check_status("async_reset", 0, 0, 0);
    $display("async reset: cnt=%0d empty=%b un=%b", oCount, oEmpty, oUnderflow);
    @(negedge iClk);
    iRst = 1'b0;
    iPush = 1'b1; iWrData = 8'h77;
    @(negedge iClk);
    iPush = 1'b0;
    check_status("post_reset_push", 1, 0, 0);
    check_rd("post_reset_push", 8'h77);
    $display("post reset push: cnt=%0d rd=%02h", oCount, oRdData);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
